mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the instruction-fetch path (IMEM side of the IFU) and the data path (MEM stage).
- Sits between the processor's iaddr/inst and DMEM interfaces and a unified memory with variable ready latency.
- Produces per-requester stall signals so the pipeline freezes while a request waits or is in flight.
- Data requests have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while i_req is pending before fetch is forced.
TIMEOUT, 16, cycles to wait for mem_ready before aborting (used only with ARB_TIMEOUT_EN).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held high until i_valid
i_addr  in  32  fetch address
i_valid  out  1  one-cycle pulse: fetch complete, i_data valid
i_data  out  32  fetched instruction
i_stall  out  1  i_req & ~i_valid (combinational)
d_req  in  1  data request; held high until d_valid
d_we  in  1  1 = store
d_addr  in  32  data address
d_wdata  in  32  store data
d_byte, d_half_word, d_sign_extend  in  1 each  access size and sign controls
d_valid  out  1  one-cycle pulse: data access complete
d_rdata  out  32  load data
d_stall  out  1  d_req & ~d_valid (combinational)
mem_req  out  1  transaction active toward memory
mem_addr, mem_wdata  out  32  latched address and store data
mem_we, mem_byte, mem_half_word, mem_sign_extend  out  1 each  latched controls; mem_we is forced 0 for fetch
mem_rdata  in  32  memory read data
mem_ready  in  1  memory completes the transaction this cycle

Behaviour:
- Reset values:
  - FSM is IDLE; the starvation counter is 0.
  - mem_req, mem_we, i_valid and d_valid are 0.
  - i_data, d_rdata, mem_addr and mem_wdata are 0.
- FSM states are IDLE, BUSY_I and BUSY_D.
- IDLE arbitration:
  - Only d_req high: grant data.
  - Only i_req high: grant fetch.
  - Both high: grant data unless the starvation counter equals STARVE_LIMIT, in which case grant fetch.
- On a grant edge:
  - Latch the granted address, controls and wdata into the mem_* registers.
  - Go to BUSY_I or BUSY_D.
  - mem_req goes high in the following cycle.
- BUSY_x:
  - mem_req stays high; mem_ready is sampled each cycle.
  - When mem_ready=1: capture mem_rdata into x_data (loads and fetch only; d_rdata holds its previous value on stores).
  - On that same edge: mem_req goes 0, x_valid pulses high for exactly 1 cycle, and the FSM returns to IDLE.
- Latency:
  - Minimum is 2 cycles from request to valid: req in cycle 0, mem_req in cycle 1 with mem_ready=1, valid in cycle 2.
  - The next grant is decided no earlier than the cycle in which valid is high, which is IDLE.
  - A requester that keeps x_req high through its valid cycle is treated as issuing a new request.
- mem_ready is ignored in IDLE.
- Starvation counter:
  - Increments on each data grant made while i_req=1.
  - Clears on a fetch grant, and on a data grant made while i_req=0.
  - Saturates at STARVE_LIMIT.
- A requester dropping x_req after its grant does not abort the transaction; valid still pulses.
- A requester dropping x_req before its grant generates no transaction.
- Reset mid-transaction:
  - Returns immediately to the reset state and drops the outstanding transaction.
  - A late mem_ready after reset is ignored (IDLE).
- Latched mem_* outputs do not change while BUSY, even if the requester's inputs change.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter starts when mem_req rises.
  - If mem_ready has not been seen after TIMEOUT mem_req cycles: drop mem_req, pulse the owner's valid, drive x_data/d_rdata=32'hDEADBEEF (stores leave d_rdata unchanged), return to IDLE.
  - Sets a sticky output port mem_err (out, 1, reset 0, cleared only by reset).
- Undefined: no counter and no mem_err port; the arbiter waits indefinitely for mem_ready.

Test Plan:
- Fetch alone: i_addr=0x100, mem_ready high in the first mem_req cycle, mem_rdata=0x20010005 -> i_valid pulses exactly 2 cycles after i_req, i_data=0x20010005, mem_we=0.
- Simultaneous i_req and d_req (load 0x2000, mem_rdata=0xCAFEF00D, ready latency 3) -> data is granted first, d_valid with d_rdata=0xCAFEF00D, then the fetch is granted the cycle after; i_stall stays high throughout.
- Starvation: d_req held continuously with i_req pending, STARVE_LIMIT=4 -> 4 data transactions complete, then the fetch is granted on the 5th arbitration and the counter clears.
- Store: d_we=1, d_addr=0x3000, d_wdata=0x12345678, d_byte=1 -> mem_* carry these values for the whole BUSY_D; d_valid pulses once; d_rdata is unchanged.
- Reset asserted in the 2nd cycle of BUSY_D, mem_ready high one cycle later -> FSM in IDLE, mem_req=0, no d_valid pulse, counter 0.
- ARB_TIMEOUT_EN defined, TIMEOUT=16, mem_ready held low -> after 16 mem_req cycles: i_valid pulse, i_data=0xDEADBEEF, mem_err=1 and remaining 1 until reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between instruction fetch and data accesses
// Ports: clock, reset (synchronous, active-high)
//   i_req/i_addr -> i_valid/i_data/i_stall : fetch request and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata/d_byte/d_half_word/d_sign_extend -> d_valid/d_rdata/d_stall : data access
//   mem_req/mem_addr/mem_wdata/mem_we/mem_byte/mem_half_word/mem_sign_extend : latched transaction to memory
//   mem_rdata/mem_ready : memory response; mem_ready completes the transaction in the cycle it is high
// Build option: define ARB_TIMEOUT_EN to abort after TIMEOUT unanswered mem_req cycles (sticky mem_err output)
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,
    output logic [31:0] i_data,
    output logic        i_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_byte,
    input  logic        d_half_word,
    input  logic        d_sign_extend,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_byte,
    output logic        mem_half_word,
    output logic        mem_sign_extend,
    input  logic [31:0] mem_rdata,
`ifdef ARB_TIMEOUT_EN
    output logic        mem_err,
`endif
    input  logic        mem_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic          mem_byte_q, mem_byte_d;
    logic          mem_half_word_q, mem_half_word_d;
    logic          mem_sign_extend_q, mem_sign_extend_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          i_valid_q, i_valid_d;
    logic          d_valid_q, d_valid_d;
    logic [31:0]   i_data_q, i_data_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          idle, done, abort, fin, take_d, take_i;
    assign idle = state_q == IDLE;
    assign done = ~idle & mem_ready;
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_err_q, mem_err_d;
    // tmo_q counts completed mem_req cycles; the abort fires on the last allowed one
    assign abort     = ~idle & ~mem_ready & (tmo_q == TMO_LAST);
    assign tmo_d     = idle ? '0 : tmo_q + 1'b1;
    assign mem_err_d = mem_err_q | abort;
    assign mem_err   = mem_err_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end
`else
    assign abort = 1'b0;
`endif
    always_comb begin
        fin               = done | abort;
        // data wins unless fetch has already waited through STARVE_LIMIT data grants
        take_d            = idle & d_req & ~(i_req & (starve_q == LIMIT));
        take_i            = idle & i_req & ~take_d;
        state_d           = take_d ? BUSY_D : take_i ? BUSY_I : fin ? IDLE : state_q;
        starve_d          = take_d & i_req ? (starve_q == LIMIT ? starve_q : starve_q + 1'b1)
                          : take_d | take_i ? '0 : starve_q;
        mem_req_d         = take_d | take_i | (mem_req_q & ~fin);
        mem_addr_d        = take_d ? d_addr : take_i ? i_addr : mem_addr_q;
        mem_wdata_d       = take_d ? d_wdata : take_i ? '0 : mem_wdata_q;
        mem_we_d          = take_d ? d_we : take_i ? 1'b0 : mem_we_q;
        mem_byte_d        = take_d ? d_byte : take_i ? 1'b0 : mem_byte_q;
        mem_half_word_d   = take_d ? d_half_word : take_i ? 1'b0 : mem_half_word_q;
        mem_sign_extend_d = take_d ? d_sign_extend : take_i ? 1'b0 : mem_sign_extend_q;
        i_valid_d         = (state_q == BUSY_I) & fin;
        d_valid_d         = (state_q == BUSY_D) & fin;
        i_data_d          = ~i_valid_d ? i_data_q : done ? mem_rdata : 32'hDEADBEEF;
        // stores complete without touching the load data register
        d_rdata_d         = ~d_valid_d | mem_we_q ? d_rdata_q : done ? mem_rdata : 32'hDEADBEEF;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IDLE;
            starve_q          <= '0;
            mem_req_q         <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            mem_we_q          <= 1'b0;
            mem_byte_q        <= 1'b0;
            mem_half_word_q   <= 1'b0;
            mem_sign_extend_q <= 1'b0;
            i_valid_q         <= 1'b0;
            d_valid_q         <= 1'b0;
            i_data_q          <= '0;
            d_rdata_q         <= '0;
        end else begin
            state_q           <= state_d;
            starve_q          <= starve_d;
            mem_req_q         <= mem_req_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            mem_we_q          <= mem_we_d;
            mem_byte_q        <= mem_byte_d;
            mem_half_word_q   <= mem_half_word_d;
            mem_sign_extend_q <= mem_sign_extend_d;
            i_valid_q         <= i_valid_d;
            d_valid_q         <= d_valid_d;
            i_data_q          <= i_data_d;
            d_rdata_q         <= d_rdata_d;
        end
    end
    assign mem_req         = mem_req_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_we          = mem_we_q;
    assign mem_byte        = mem_byte_q;
    assign mem_half_word   = mem_half_word_q;
    assign mem_sign_extend = mem_sign_extend_q;
    assign i_valid         = i_valid_q;
    assign d_valid         = d_valid_q;
    assign i_data          = i_data_q;
    assign d_rdata         = d_rdata_q;
    assign i_stall         = i_req & ~i_valid_q;
    assign d_stall         = d_req & ~d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int STARVE_LIMIT = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TIMEOUT = 16;
    logic        mem_err;
    int          waited;
    logic        m_err;
`endif
    logic        clock = 1'b0;
    logic        reset, i_req, d_req, d_we, d_byte, d_half_word, d_sign_extend, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_valid, i_stall, d_valid, d_stall, mem_req, mem_we, mem_byte, mem_half_word, mem_sign_extend;
    logic [31:0] i_data, d_rdata, mem_addr, mem_wdata;
    typedef struct packed {
        logic        act, is_d, we, b, h, s;
        logic [31:0] addr, wdata;
    } txn_t;
    txn_t        cur;
    int          starve, n_chk, n_fail;
    logic        m_ivalid, m_dvalid;
    logic [31:0] m_idata, m_drdata;
    always #5 clock = ~clock;
    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_data(i_data), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_byte(d_byte),
        .d_half_word(d_half_word), .d_sign_extend(d_sign_extend),
        .d_valid(d_valid), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_byte(mem_byte), .mem_half_word(mem_half_word), .mem_sign_extend(mem_sign_extend),
        .mem_rdata(mem_rdata),
`ifdef ARB_TIMEOUT_EN
        .mem_err(mem_err),
`endif
        .mem_ready(mem_ready)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask
    task automatic model_step();
        bit timed_out, pick_d;
        timed_out = 0;
        m_ivalid  = 0;
        m_dvalid  = 0;
        if (reset) begin
            cur      = '0;
            starve   = 0;
            m_idata  = 0;
            m_drdata = 0;
`ifdef ARB_TIMEOUT_EN
            waited   = 0;
            m_err    = 0;
`endif
        end else if (cur.act) begin
`ifdef ARB_TIMEOUT_EN
            if (!mem_ready) begin
                waited++;
                timed_out = waited == TIMEOUT;
                if (timed_out) m_err = 1;
            end
`endif
            if (mem_ready || timed_out) begin
                cur.act = 0;
                if (cur.is_d) begin
                    m_dvalid = 1;
                    if (!cur.we) m_drdata = mem_ready ? mem_rdata : 32'hDEADBEEF;
                end else begin
                    m_ivalid = 1;
                    m_idata  = mem_ready ? mem_rdata : 32'hDEADBEEF;
                end
            end
        end else if (i_req || d_req) begin
            pick_d = d_req && !(i_req && starve == STARVE_LIMIT);
            cur    = pick_d ? {1'b1, 1'b1, d_we, d_byte, d_half_word, d_sign_extend, d_addr, d_wdata}
                            : {1'b1, 1'b0, 4'b0, i_addr, 32'h0};
            starve = (pick_d && i_req) ? starve + 1 : 0;
`ifdef ARB_TIMEOUT_EN
            waited = 0;
`endif
        end
    endtask
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("mem_req", mem_req, cur.act);
        check("mem_addr", mem_addr, cur.addr);
        check("mem_we", mem_we, cur.we);
        if (cur.is_d) begin
            check("mem_wdata", mem_wdata, cur.wdata);
            check("mem_byte", mem_byte, cur.b);
            check("mem_half_word", mem_half_word, cur.h);
            check("mem_sign_extend", mem_sign_extend, cur.s);
        end
        check("i_valid", i_valid, m_ivalid);
        check("d_valid", d_valid, m_dvalid);
        check("i_data", i_data, m_idata);
        check("d_rdata", d_rdata, m_drdata);
        check("i_stall", i_stall, i_req & ~m_ivalid);
        check("d_stall", d_stall, d_req & ~m_dvalid);
`ifdef ARB_TIMEOUT_EN
        check("mem_err", mem_err, m_err);
`endif
    endtask
    initial begin
        int n_dv;
        bit got_i;
        n_chk = 0; n_fail = 0; cur = '0; starve = 0;
        m_ivalid = 0; m_dvalid = 0; m_idata = 0; m_drdata = 0;
        reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d_byte = 0; d_half_word = 0; d_sign_extend = 0; mem_rdata = 0; mem_ready = 0;
        tick(); tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_i_valid", i_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_i_data", i_data, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset = 0;
        i_req = 1; i_addr = 32'h100; tick();
        check("fetch_grant", mem_req, 1);
        check("fetch_we", mem_we, 0);
        check("fetch_valid_early", i_valid, 0);
        mem_ready = 1; mem_rdata = 32'h20010005; tick();
        check("fetch_valid", i_valid, 1);
        check("fetch_data", i_data, 32'h20010005);
        i_req = 0; tick();
        check("fetch_pulse", i_valid, 0);
        check("idle_ready_ignored", mem_req, 0);
        mem_ready = 0; i_req = 1; i_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000;
        mem_rdata = 32'hCAFEF00D; tick();
        check("both_grant_d", mem_addr, 32'h2000);
        tick(); tick();
        mem_ready = 1; tick();
        check("both_dvalid", d_valid, 1);
        check("both_drdata", d_rdata, 32'hCAFEF00D);
        check("both_istall", i_stall, 1);
        d_req = 0; mem_ready = 0; tick();
        check("both_grant_i", mem_addr, 32'h104);
        check("both_i_req", mem_req, 1);
        mem_ready = 1; mem_rdata = 32'h00000013; tick();
        check("both_ivalid", i_valid, 1);
        i_req = 0; mem_ready = 0; tick();
        d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'h12345678; d_byte = 1; mem_rdata = 32'h55555555;
        tick();
        d_addr = 32'h3FF0; d_wdata = 32'hFFFFFFFF; d_byte = 0; d_we = 0;
        for (int k = 0; k < 3; k++) begin
            check("store_addr", mem_addr, 32'h3000);
            check("store_wdata", mem_wdata, 32'h12345678);
            check("store_byte", mem_byte, 1);
            check("store_we", mem_we, 1);
            mem_ready = (k == 2);
            tick();
        end
        check("store_dvalid", d_valid, 1);
        check("store_rdata_kept", d_rdata, 32'hCAFEF00D);
        d_req = 0; mem_ready = 0; tick();
        check("store_pulse", d_valid, 0);
        reset = 1; tick(); reset = 0;
        i_req = 1; i_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h4000; mem_ready = 1; mem_rdata = 32'h1111;
        n_dv = 0; got_i = 0;
        for (int k = 0; k < 12 && !got_i; k++) begin
            tick();
            if (d_valid) n_dv++;
            if (mem_req && mem_addr == 32'h500) got_i = 1;
        end
        check("starve_data_count", n_dv, STARVE_LIMIT);
        check("starve_fetch_granted", got_i, 1);
        tick();
        check("starve_fetch_done", i_valid, 1);
        tick();
        check("starve_cleared_grant_d", mem_addr, 32'h4000);
        i_req = 0; d_req = 0; tick(); tick();
        mem_ready = 0; d_req = 1; d_addr = 32'h6000; tick();
        tick();
        reset = 1; d_req = 0; tick();
        reset = 0; mem_ready = 1; tick();
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_dvalid", d_valid, 0);
        tick();
        check("rst_mid_late_ready", d_valid, 0);
`ifdef ARB_TIMEOUT_EN
        mem_ready = 0; i_req = 1; i_addr = 32'h700; tick();
        i_req = 0;
        for (int k = 0; k < TIMEOUT; k++) begin
            check("tmo_waiting", i_valid, 0);
            tick();
        end
        check("tmo_ivalid", i_valid, 1);
        check("tmo_data", i_data, 32'hDEADBEEF);
        check("tmo_err", mem_err, 1);
        check("tmo_req_drop", mem_req, 0);
        tick(); tick();
        check("tmo_err_sticky", mem_err, 1);
        reset = 1; tick(); reset = 0;
        check("tmo_err_cleared", mem_err, 0);
`endif
        for (int n = 0; n < 4000; n++) begin
            reset = $urandom_range(0, 249) == 0;
            if (m_ivalid || !i_req) begin
                i_req  = $urandom_range(0, 1) == 1;
                i_addr = $urandom;
            end else if ($urandom_range(0, 39) == 0) i_req = 0;
            if (m_dvalid || !d_req) begin
                d_req = $urandom_range(0, 1) == 1;
                {d_we, d_byte, d_half_word, d_sign_extend} = 4'($urandom);
                d_addr  = $urandom;
                d_wdata = $urandom;
            end else if ($urandom_range(0, 39) == 0) d_req = 0;
            if (cur.act && cur.is_d) d_wdata = $urandom;
            if (cur.act && !cur.is_d) i_addr = $urandom;
            mem_ready = $urandom_range(0, 2) == 0;
            mem_rdata = $urandom;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
